id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly downstream of RegisterFile. Latches BusA/BusB

---
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding from EX/MEM/WB,
// load-use hazard detection with bubble insertion, hold and flush.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 16
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic [DW-1:0] BusA,
   input  logic [DW-1:0] BusB,
   input  logic [AW-1:0] RA,
   input  logic [AW-1:0] RB,
   input  logic [AW-1:0] RW_id,
   input  logic          RegWr_id,
   input  logic          MemRd_id,
   input  logic [DW-1:0] Imm_id,
   input  logic          Valid_id,
   input  logic [DW-1:0] Ex_Result,
   input  logic [DW-1:0] Mem_Result,
   input  logic [AW-1:0] Mem_RW,
   input  logic          Mem_RegWr,
   input  logic [DW-1:0] BusW,
   input  logic [AW-1:0] RW,
   input  logic          RegWr,
   input  logic          Hold,
   input  logic          Flush,
   output logic [DW-1:0] Ex_A,
   output logic [DW-1:0] Ex_B,
   output logic [AW-1:0] Ex_RW,
   output logic          Ex_RegWr,
   output logic          Ex_MemRd,
   output logic [DW-1:0] Ex_Imm,
   output logic          Ex_Valid,
   output logic          HazardStall,
   output logic [CW-1:0] BubbleCnt
);

   logic [DW-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [AW-1:0] rw_q, rw_d;
   logic          regwr_q, regwr_d;
   logic          memrd_q, memrd_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] fwd_a, fwd_b;
   logic          ex_alu;

   // A load in EX has no result yet, so only ALU results forward from EX
   assign ex_alu = valid_q & regwr_q & ~memrd_q;

   function automatic logic [DW-1:0] fwd(
      input logic [AW-1:0] src,
      input logic [DW-1:0] rf
   );
      if (src == '0)
         return '0;
      else if (ex_alu && rw_q == src)
         return Ex_Result;
      else if (Mem_RegWr && Mem_RW == src)
         return Mem_Result;
      else if (RegWr && RW == src)
         return BusW;
      else
         return rf;
   endfunction

   always_comb begin
      fwd_a = fwd(RA, BusA);
      fwd_b = fwd(RB, BusB);
   end

   assign HazardStall = valid_q & memrd_q & regwr_q & Valid_id &
                        (rw_q != '0) & ((rw_q == RA) | (rw_q == RB));

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      rw_d    = rw_q;
      regwr_d = regwr_q;
      memrd_d = memrd_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (Flush || (!Hold && (HazardStall || !Valid_id))) begin
         a_d     = '0;
         b_d     = '0;
         imm_d   = '0;
         rw_d    = '0;
         regwr_d = 1'b0;
         memrd_d = 1'b0;
         valid_d = 1'b0;
         if (!Flush && HazardStall && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
      end else if (!Hold) begin
         a_d     = fwd_a;
         b_d     = fwd_b;
         imm_d   = Imm_id;
         rw_d    = RW_id;
         regwr_d = RegWr_id;
         memrd_d = MemRd_id;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         rw_q    <= '0;
         regwr_q <= 1'b0;
         memrd_q <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         rw_q    <= rw_d;
         regwr_q <= regwr_d;
         memrd_q <= memrd_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Ex_A      = a_q;
   assign Ex_B      = b_q;
   assign Ex_Imm    = imm_q;
   assign Ex_RW     = rw_q;
   assign Ex_RegWr  = regwr_q;
   assign Ex_MemRd  = memrd_q;
   assign Ex_Valid  = valid_q;
   assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and model-checked bench for id_ex_stage,
// plus a CW=2 instance for counter saturation.
module tb_id_ex_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] BusA, BusB, Imm_id, Ex_Result, Mem_Result, BusW;
   logic [4:0]  RA, RB, RW_id, Mem_RW, RW;
   logic        RegWr_id, MemRd_id, Valid_id, Mem_RegWr, RegWr;
   logic        Hold, Flush;

   logic [31:0] Ex_A, Ex_B, Ex_Imm;
   logic [4:0]  Ex_RW;
   logic        Ex_RegWr, Ex_MemRd, Ex_Valid, HazardStall;
   logic [15:0] BubbleCnt;

   logic [31:0] a2, b2, imm2;
   logic [4:0]  rw2;
   logic        regwr2, memrd2, valid2, hz2;
   logic [1:0]  cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   id_ex_stage dut (
      .Clk(Clk), .Rst(Rst), .BusA(BusA), .BusB(BusB), .RA(RA), .RB(RB),
      .RW_id(RW_id), .RegWr_id(RegWr_id), .MemRd_id(MemRd_id),
      .Imm_id(Imm_id), .Valid_id(Valid_id), .Ex_Result(Ex_Result),
      .Mem_Result(Mem_Result), .Mem_RW(Mem_RW), .Mem_RegWr(Mem_RegWr),
      .BusW(BusW), .RW(RW), .RegWr(RegWr), .Hold(Hold), .Flush(Flush),
      .Ex_A(Ex_A), .Ex_B(Ex_B), .Ex_RW(Ex_RW), .Ex_RegWr(Ex_RegWr),
      .Ex_MemRd(Ex_MemRd), .Ex_Imm(Ex_Imm), .Ex_Valid(Ex_Valid),
      .HazardStall(HazardStall), .BubbleCnt(BubbleCnt)
   );

   id_ex_stage #(.CW(2)) dut2 (
      .Clk(Clk), .Rst(Rst), .BusA(BusA), .BusB(BusB), .RA(RA), .RB(RB),
      .RW_id(RW_id), .RegWr_id(RegWr_id), .MemRd_id(MemRd_id),
      .Imm_id(Imm_id), .Valid_id(Valid_id), .Ex_Result(Ex_Result),
      .Mem_Result(Mem_Result), .Mem_RW(Mem_RW), .Mem_RegWr(Mem_RegWr),
      .BusW(BusW), .RW(RW), .RegWr(RegWr), .Hold(Hold), .Flush(Flush),
      .Ex_A(a2), .Ex_B(b2), .Ex_RW(rw2), .Ex_RegWr(regwr2),
      .Ex_MemRd(memrd2), .Ex_Imm(imm2), .Ex_Valid(valid2),
      .HazardStall(hz2), .BubbleCnt(cnt2)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Rst = 0; Hold = 0; Flush = 0;
      BusA = 0; BusB = 0; Imm_id = 0; Ex_Result = 0;
      Mem_Result = 0; BusW = 0;
      RA = 0; RB = 0; RW_id = 0; Mem_RW = 0; RW = 0;
      RegWr_id = 0; MemRd_id = 0; Valid_id = 0;
      Mem_RegWr = 0; RegWr = 0;
   endtask

   task automatic rand_in();
      BusA = $urandom; BusB = $urandom; Imm_id = $urandom;
      Ex_Result = $urandom; Mem_Result = $urandom; BusW = $urandom;
      RA = 5'($urandom_range(0, 3)); RB = 5'($urandom_range(0, 3));
      RW_id = 5'($urandom_range(0, 3));
      Mem_RW = 5'($urandom_range(0, 3));
      RW = 5'($urandom_range(0, 3));
      RegWr_id = 1'($urandom); MemRd_id = 1'($urandom);
      Valid_id = ($urandom_range(0, 3) != 0);
      Mem_RegWr = 1'($urandom); RegWr = 1'($urandom);
      Hold = ($urandom_range(0, 7) == 0);
      Flush = ($urandom_range(0, 15) == 0);
   endtask

   // reference model state
   logic [31:0] m_a, m_b, m_imm;
   logic [4:0]  m_rw;
   logic        m_wr, m_mr, m_v, m_hz;
   logic [15:0] m_cnt;

   function automatic logic [31:0] m_fwd(input logic [4:0] s,
                                         input logic [31:0] rf);
      logic [31:0] r;
      r = rf;
      if (RegWr && RW == s) r = BusW;
      if (Mem_RegWr && Mem_RW == s) r = Mem_Result;
      if (m_v && m_wr && !m_mr && m_rw == s) r = Ex_Result;
      if (s == 0) r = 0;
      return r;
   endfunction

   task automatic m_step();
      logic [31:0] fa, fb;
      fa = m_fwd(RA, BusA);
      fb = m_fwd(RB, BusB);
      m_hz = m_v && m_mr && m_wr && Valid_id && m_rw != 0 &&
             (m_rw == RA || m_rw == RB);
      if (Rst) begin
         {m_a, m_b, m_imm, m_rw, m_wr, m_mr, m_v} = '0;
         m_cnt = 0;
      end else if (Flush) begin
         {m_a, m_b, m_imm, m_rw, m_wr, m_mr, m_v} = '0;
      end else if (Hold) begin
      end else if (m_hz) begin
         {m_a, m_b, m_imm, m_rw, m_wr, m_mr, m_v} = '0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else if (!Valid_id) begin
         {m_a, m_b, m_imm, m_rw, m_wr, m_mr, m_v} = '0;
      end else begin
         m_a = fa; m_b = fb; m_imm = Imm_id; m_rw = RW_id;
         m_wr = RegWr_id; m_mr = MemRd_id; m_v = 1;
      end
   endtask

   initial begin
      idle();
      // 1: reset with random inputs, then a first load
      rand_in();
      Rst = 1;
      tick();
      rand_in();
      Rst = 1;
      tick();
      check("rst_data", {Ex_A, Ex_B}, 64'h0);
      check("rst_imm", {32'h0, Ex_Imm}, 64'h0);
      check("rst_ctl", {Ex_RW, Ex_RegWr, Ex_MemRd, Ex_Valid}, 64'h0);
      check("rst_cnt", {BubbleCnt, 2'(cnt2)}, 64'h0);
      check("rst_hz", HazardStall, 0);
      idle();
      RA = 3; BusA = 32'h11; RW_id = 9; RegWr_id = 1; Valid_id = 1;
      tick();
      check("load_a", Ex_A, 32'h11);
      check("load_ctl", {Ex_RW, Ex_RegWr, Ex_Valid}, {5'd9, 2'b11});

      // 2: forwarding priority EX > MEM > WB > RF
      idle();
      RW_id = 5; RegWr_id = 1; Valid_id = 1;
      tick();
      Ex_Result = 32'hAA; Mem_RW = 5; Mem_RegWr = 1; Mem_Result = 32'hBB;
      RW = 5; RegWr = 1; BusW = 32'hCC; RA = 5; BusA = 32'h12;
      RB = 5; BusB = 32'h34; RW_id = 6;
      tick();
      check("fwd_ex", Ex_A, 32'hAA);
      tick();
      check("fwd_mem_a", Ex_A, 32'hBB);
      check("fwd_mem_b", Ex_B, 32'hBB);
      Mem_RegWr = 0;
      tick();
      check("fwd_wb", Ex_A, 32'hCC);
      RegWr = 0;
      tick();
      check("fwd_rf", {Ex_A, Ex_B}, {32'h12, 32'h34});

      // 3: r0 never forwarded
      idle();
      RW_id = 0; RegWr_id = 1; Valid_id = 1;
      tick();
      Ex_Result = '1; Mem_Result = '1; Mem_RegWr = 1; BusW = '1;
      RegWr = 1; BusA = '1; BusB = '1;
      tick();
      check("r0", {Ex_A, Ex_B}, 64'h0);

      // 4: load-use hazard
      idle();
      RW_id = 7; RegWr_id = 1; MemRd_id = 1; Valid_id = 1;
      tick();
      check("ld_memrd", Ex_MemRd, 1);
      RA = 2; RB = 7; BusB = 32'h99; RW_id = 8; MemRd_id = 0;
      #1;
      check("hz_on", HazardStall, 1);
      tick();
      check("hz_bubble", {Ex_Valid, Ex_B}, 0);
      check("hz_cnt", BubbleCnt, 1);
      check("hz_off", HazardStall, 0);
      Mem_RW = 7; Mem_RegWr = 1; Mem_Result = 32'h55;
      tick();
      check("hz_fwd", {Ex_Valid, Ex_B}, {1'b1, 32'h55});
      idle();
      RW_id = 0; RegWr_id = 1; MemRd_id = 1; Valid_id = 1;
      tick();
      RW_id = 1; MemRd_id = 0;
      #1;
      check("hz_r0", HazardStall, 0);

      // 5: flush beats hold and hazard; hold freezes
      idle();
      RW_id = 7; RegWr_id = 1; MemRd_id = 1; Valid_id = 1;
      tick();
      MemRd_id = 0; RW_id = 2; RA = 7; Flush = 1; Hold = 1;
      #1;
      check("fl_hz", HazardStall, 1);
      tick();
      check("fl_bub", {Ex_Valid, Ex_RW, Ex_MemRd, Ex_RegWr}, 0);
      check("fl_cnt", BubbleCnt, 1);
      idle();
      RA = 3; BusA = 32'h77; RW_id = 3; RegWr_id = 1; Valid_id = 1;
      Imm_id = 32'h1234;
      tick();
      Hold = 1; RA = 4; BusA = 32'h88; Imm_id = 32'h5678; RW_id = 9;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold", {Ex_A, Ex_Imm[15:0], Ex_RW, Ex_Valid, Ex_RegWr},
               {32'h77, 16'h1234, 5'd3, 2'b11});
      end
      check("hold_cnt", BubbleCnt, 1);

      // 6: saturation of a 2-bit counter
      idle();
      Rst = 1;
      tick();
      for (int i = 0; i < 5; i++) begin
         idle();
         RW_id = 7; RegWr_id = 1; MemRd_id = 1; Valid_id = 1;
         tick();
         RA = 7; RW_id = 1; MemRd_id = 0;
         tick();
      end
      check("sat_cw2", cnt2, 3);
      check("cnt_cw16", BubbleCnt, 5);

      // random run against the model
      idle();
      Rst = 1;
      m_step();
      tick();
      for (int i = 0; i < 5000; i++) begin
         rand_in();
         Rst = ($urandom_range(0, 63) == 0);
         m_step();
         #1;
         check("rnd_hz", HazardStall, m_hz);
         tick();
         check("rnd_ab", {Ex_A, Ex_B}, {m_a, m_b});
         check("rnd_ctl",
               {Ex_Imm, Ex_RW, Ex_RegWr, Ex_MemRd, Ex_Valid, BubbleCnt},
               {m_imm, m_rw, m_wr, m_mr, m_v, m_cnt});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
